demux_rr_dispatcher: RTL

Single-entry buffered dispatcher that accepts a data stream and routes each word to one of four output channels. It selects channels round-robin or by a fixed selection, skipping channels whose enable bit is low, and counts words delivered per channel. It sits in front of the 1-to-4 demultiplexer: it drives that block's select pair and enable, and owns the valid/ready handshakes on both sides.

---
 rtl/demux_rr_dispatcher.sv | 92 +++++++++
 1 files changed

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: single-entry buffer routing each word to one of four channels
module demux_rr_dispatcher #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       ch_en,
  input  logic             mode,
  input  logic [1:0]       fix_sel,
  input  logic [3:0]       out_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             dmx_a,
  output logic             dmx_b,
  output logic             dmx_f,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [1:0]       sel_q, sel_d, ptr_q, ptr_d;
  logic [1:0]       base, rr_sel, nxt, idx;
  logic             rr_ok, avail, xfer, acc;
  logic [CNT_W-1:0] cnt_q [4];
  assign xfer = full_q & out_ready[sel_q];
  // a same-cycle transfer moves the pointer, so the search already starts past it
  assign base = xfer ? sel_q + 2'd1 : ptr_q;
  // first enabled channel at or after base; scanned backwards so the nearest wins
  always_comb begin
    rr_sel = base;
    rr_ok  = 1'b0;
    idx    = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (ch_en[idx]) begin
        rr_sel = idx;
        rr_ok  = 1'b1;
      end
    end
  end
  assign nxt      = mode ? fix_sel : rr_sel;
  assign avail    = mode ? ch_en[fix_sel] : rr_ok;
  assign in_ready = avail & (~full_q | xfer);
  assign acc      = in_valid & in_ready;
  // buffer next state: a held word is committed until it transfers
  always_comb begin
    full_d = acc | (full_q & ~xfer);
    hold_d = acc ? in_data : hold_q;
    sel_d  = acc ? nxt : sel_q;
    ptr_d  = xfer ? sel_q + 2'd1 : ptr_q;
  end
  // buffer and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      hold_q <= '0;
      sel_q  <= 2'd0;
      ptr_q  <= 2'd0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end
  // per-channel delivery counters; clear wins over a same-cycle delivery
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (xfer) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
    end
  end
  assign out_valid = {4{full_q}} & (4'b0001 << sel_q);
  assign out_data  = hold_q;
  assign dmx_a     = sel_q[0];
  assign dmx_b     = sel_q[1];
  assign dmx_f     = full_q;
  assign busy      = full_q;
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];
endmodule
